// File: rtl/gas_alarm_ctrl_pkg.sv
// gas_alarm_ctrl_pkg: state encoding and default timing constants for the gas alarm back-end.
// Rev 1.0
`default_nettype none

package gas_alarm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ALARM    = 2'd1,
    ST_CLEARING = 2'd2,
    ST_MUTED    = 2'd3
  } state_t;

  localparam int DEF_DEB_CYC     = 50_000;
  localparam int DEF_TONE_HALF   = 12_500;
  localparam int DEF_CADENCE_CYC = 12_500_000;
  localparam int DEF_HOLD_CYC    = 100_000_000;

  function automatic logic alarm_sounding(input state_t st);
    return (st == ST_ALARM) || (st == ST_CLEARING);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gas_alarm_ctrl_debounce.sv
// gas_alarm_ctrl_debounce: 2-flop synchronizer plus stability filter for the raw gas level.
// Rev 1.0
`default_nettype none

module gas_alarm_ctrl_debounce
  import gas_alarm_ctrl_pkg::*;
#(
  parameter int DEB_CYC = DEF_DEB_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic gas_signal,
  output logic gas_f
);

  localparam int            CW       = $clog2(DEB_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1;
  logic          gas_s;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      gas_s <= 1'b0;
      gas_f <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= gas_signal;
      gas_s <= sync1;
      // Any agreeing cycle restarts the stability window.
      if (gas_s == gas_f) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        gas_f <= ~gas_f;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/gas_alarm_ctrl.sv
// gas_alarm_ctrl: alarm FSM, buzzer cadence/tone and LED driver; GAS_ALARM_LATCH_EN latches the alarm until ack.
// Rev 1.0
`default_nettype none

module gas_alarm_ctrl
  import gas_alarm_ctrl_pkg::*;
#(
  parameter int DEB_CYC     = DEF_DEB_CYC,
  parameter int TONE_HALF   = DEF_TONE_HALF,
  parameter int CADENCE_CYC = DEF_CADENCE_CYC,
  parameter int HOLD_CYC    = DEF_HOLD_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic gas_signal,
  input  logic ack,
  output logic buzzer,
  output logic alarm_led,
  output logic alarm_active,
  output logic alarm_event
);

  localparam int            TW        = $clog2(TONE_HALF + 1);
  localparam int            CW        = $clog2(2 * CADENCE_CYC + 1);
  localparam int            HW        = $clog2(HOLD_CYC + 1);
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);
  localparam logic [TW-1:0] TONE_ONE  = TW'(1);
  localparam logic [CW-1:0] CAD_LAST  = CW'(2 * CADENCE_CYC - 1);
  localparam logic [CW-1:0] CAD_ON    = CW'(CADENCE_CYC);
  localparam logic [CW-1:0] CAD_ONE   = CW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  logic          gas_f;
  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cad_cnt;
  logic [CW-1:0] cad_nxt;
  logic [TW-1:0] tone_cnt;
  logic [TW-1:0] tone_nxt;
  logic          tone_lvl;
  logic          tone_lvl_nxt;
  logic [HW-1:0] hold_cnt;

  gas_alarm_ctrl_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .gas_signal (gas_signal),
    .gas_f      (gas_f)
  );

  // Ack is evaluated before gas_f so a coincident ack always wins.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (gas_f) state_nxt = ST_ALARM;
      end
      ST_ALARM: begin
`ifdef GAS_ALARM_LATCH_EN
        if (ack) state_nxt = gas_f ? ST_MUTED : ST_IDLE;
`else
        if (ack)         state_nxt = ST_MUTED;
        else if (!gas_f) state_nxt = ST_CLEARING;
`endif
      end
      ST_CLEARING: begin
        if (ack)                       state_nxt = ST_IDLE;
        else if (gas_f)                state_nxt = ST_ALARM;
        else if (hold_cnt == HOLD_LAST) state_nxt = ST_IDLE;
      end
      ST_MUTED: begin
        if (!gas_f) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Cadence position and tone phase for the cycle after this one.
  always_comb begin
    cad_nxt = (cad_cnt == CAD_LAST) ? '0 : cad_cnt + CAD_ONE;
    if (cad_nxt == '0) begin
      tone_nxt     = '0;
      tone_lvl_nxt = 1'b1;
    end else if (tone_cnt == TONE_LAST) begin
      tone_nxt     = '0;
      tone_lvl_nxt = ~tone_lvl;
    end else begin
      tone_nxt     = tone_cnt + TONE_ONE;
      tone_lvl_nxt = tone_lvl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cad_cnt      <= '0;
      tone_cnt     <= '0;
      tone_lvl     <= 1'b0;
      hold_cnt     <= '0;
      buzzer       <= 1'b0;
      alarm_led    <= 1'b0;
      alarm_active <= 1'b0;
      alarm_event  <= 1'b0;
    end else begin
      state        <= state_nxt;
      alarm_active <= (state_nxt != ST_IDLE);
      alarm_event  <= (state == ST_IDLE) && (state_nxt == ST_ALARM);

      if (state == ST_CLEARING && state_nxt == ST_CLEARING)
        hold_cnt <= (hold_cnt == HOLD_LAST) ? '0 : hold_cnt + HOLD_ONE;
      else
        hold_cnt <= '0;

      if (alarm_sounding(state_nxt)) begin
        if (state == ST_IDLE) begin
          // Fresh alarm: cadence and tone start at the top of an on-phase.
          cad_cnt   <= '0;
          tone_cnt  <= '0;
          tone_lvl  <= 1'b1;
          buzzer    <= 1'b1;
          alarm_led <= 1'b1;
        end else begin
          cad_cnt   <= cad_nxt;
          tone_cnt  <= tone_nxt;
          tone_lvl  <= tone_lvl_nxt;
          buzzer    <= (cad_nxt < CAD_ON) && tone_lvl_nxt;
          alarm_led <= (cad_nxt < CAD_ON);
        end
      end else if (state_nxt == ST_MUTED) begin
        buzzer    <= 1'b0;
        alarm_led <= 1'b1;
      end else begin
        buzzer    <= 1'b0;
        alarm_led <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gas_alarm_ctrl.sv
// tb_gas_alarm_ctrl: scoreboard bench comparing gas_alarm_ctrl against a cycle-level reference model.
// Rev 1.0
`default_nettype none

module tb_gas_alarm_ctrl;

  localparam int DEB  = 4;
  localparam int TH   = 2;
  localparam int CAD  = 8;
  localparam int HOLD = 10;
`ifdef GAS_ALARM_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  localparam int M_IDLE = 0, M_ALARM = 1, M_CLR = 2, M_MUTED = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic gas_signal = 1'b0;
  logic ack = 1'b0;
  logic buzzer, alarm_led, alarm_active, alarm_event;

  int total = 0;
  int bad = 0;

  gas_alarm_ctrl #(
    .DEB_CYC     (DEB),
    .TONE_HALF   (TH),
    .CADENCE_CYC (CAD),
    .HOLD_CYC    (HOLD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .gas_signal   (gas_signal),
    .ack          (ack),
    .buzzer       (buzzer),
    .alarm_led    (alarm_led),
    .alarm_active (alarm_active),
    .alarm_event  (alarm_event)
  );

  always #5 clk = ~clk;

  // Expected {alarm_active, alarm_event, buzzer, alarm_led} after each clock edge.
  logic [3:0] expq[$];

  bit samp[$];
  bit gsh[$];
  bit m_gf;
  int m_st;
  int m_t;
  int m_age;

  function void check(input string name, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got act/evt/buz/led=%b expected %b", name, $time, got, exp);
    end
  endfunction

  function void model_reset();
    samp.delete();
    gsh.delete();
    m_gf  = 1'b0;
    m_st  = M_IDLE;
    m_t   = 0;
    m_age = 0;
  endfunction

  function void model_step(input bit g, input bit a, input bit r);
    bit ev;
    bit gfo;
    bit all;
    bit gsv;
    bit on;
    bit buz;
    bit led;
    int k;
    int p;
    if (!r) begin
      model_reset();
      expq.push_back(4'b0000);
      return;
    end
    ev  = 1'b0;
    gfo = m_gf;
    case (m_st)
      M_IDLE: if (gfo) begin m_st = M_ALARM; m_t = 0; ev = 1'b1; end
      M_ALARM: begin
        if (a)                  m_st = (LATCH && !gfo) ? M_IDLE : M_MUTED;
        else if (!gfo && !LATCH) begin m_st = M_CLR; m_age = 0; m_t++; end
        else                    m_t++;
      end
      M_CLR: begin
        if (a)                     m_st = M_IDLE;
        else if (gfo)              begin m_st = M_ALARM; m_t++; end
        else if (m_age == HOLD - 1) m_st = M_IDLE;
        else                       begin m_age++; m_t++; end
      end
      default: if (!gfo) m_st = M_IDLE;
    endcase
    // Level seen by the filter lags the pin by two edges; it flips after DEB disagreeing edges in a row.
    samp.push_back(g);
    k   = samp.size() - 1;
    gsv = (k >= 2) ? samp[k-2] : 1'b0;
    gsh.push_back(gsv);
    if (gsh.size() >= DEB) begin
      all = 1'b1;
      for (int i = 0; i < DEB; i++)
        if (gsh[gsh.size()-1-i] == m_gf) all = 1'b0;
      if (all) m_gf = !m_gf;
    end
    p   = m_t % (2 * CAD);
    on  = (p < CAD);
    buz = 1'b0;
    led = 1'b0;
    if (m_st == M_ALARM || m_st == M_CLR) begin
      led = on;
      buz = on && (((p / TH) % 2) == 0);
    end else if (m_st == M_MUTED) begin
      led = 1'b1;
    end
    expq.push_back({m_st != M_IDLE, ev, buz, led});
  endfunction

  task automatic cyc(input bit g, input bit a, input bit r);
    @(negedge clk);
    #1;
    gas_signal = g;
    ack        = a;
    if (!r && rst_n) begin
      rst_n = 1'b0;
      #1;
      check("async_reset", {alarm_active, alarm_event, buzzer, alarm_led}, 4'b0000);
    end
    rst_n = r;
    model_step(g, a, r);
  endtask

  task automatic hold_gas(input bit g, input int n);
    repeat (n) cyc(g, 1'b0, 1'b1);
  endtask

  initial begin : monitor
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("outputs", {alarm_active, alarm_event, buzzer, alarm_led}, e);
      end
    end
  end

  initial begin : stim
    bit g;
    bit a;
    bit last_a;
    int run;
    model_reset();
    #1;
    check("reset_state", {alarm_active, alarm_event, buzzer, alarm_led}, 4'b0000);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    // Glitch shorter than the filter window.
    hold_gas(1'b0, 5);
    hold_gas(1'b1, 3);
    hold_gas(1'b0, 10);

    // Clean detect and several full cadence periods.
    hold_gas(1'b1, 40);

    // Ack mutes, clearing gas returns to idle.
    cyc(1'b1, 1'b1, 1'b1);
    hold_gas(1'b1, 3);
    hold_gas(1'b0, 12);

    // Auto-clear through CLEARING, then a gas return while clearing.
    hold_gas(1'b1, 14);
    hold_gas(1'b0, 22);
    hold_gas(1'b1, 14);
    hold_gas(1'b0, 6);
    hold_gas(1'b1, 16);

    // Ack lands on the same edge the filtered gas falls.
    hold_gas(1'b0, 6);
    cyc(1'b0, 1'b1, 1'b1);
    hold_gas(1'b0, 6);

    // Asynchronous reset in the middle of an alarm.
    hold_gas(1'b1, 12);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    hold_gas(1'b0, 10);

    // Ack in idle does nothing.
    cyc(1'b0, 1'b1, 1'b1);
    hold_gas(1'b0, 4);

    // Randomized gas runs with sparse acks and rare resets.
    last_a = 1'b0;
    for (int n = 0; n < 120; n++) begin
      g   = $urandom_range(0, 1);
      run = (($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 30));
      for (int j = 0; j < run; j++) begin
        a = (!last_a) && ($urandom_range(0, 11) == 0);
        last_a = a;
        if ($urandom_range(0, 399) == 0) begin
          cyc(g, 1'b0, 1'b0);
          cyc(g, 1'b0, 1'b0);
        end else begin
          cyc(g, a, 1'b1);
        end
      end
    end

    hold_gas(1'b0, 2);
    @(negedge clk);
    #2;
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries, expected 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
